decode_1st_queue: RTL and testbench
===================================

DECODE_1ST_QUEUE -- requirements
Module: decode_1st_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instructions (power of 2, >=2).
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the PC path.
REQ-003 SHALL have port CLK  in  1  clock; all state changes on posedge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port FLUSH  in  1  synchronous queue discard.
REQ-006 SHALL have ports INST_VALID in 1, INST_READY out 1, INST_PC in PC_WIDTH, INST_DATA in 32: the fetch-side push handshake.
REQ-007 SHALL have ports DECODE_VALID out 1 and DECODE_READY in 1: the decode-2 pop handshake.
REQ-008 SHALL have outputs DECODE_PC (PC_WIDTH), OPCODE (7), RD/RS1/RS2 (5 each), FUNCT3 (3), FUNCT7 (7): head-entry fields.
REQ-009 SHALL have outputs DECODE_IMM (32, sign-extended immediate for the head entry) and DECODE_IMM_FMT (3, format code).
REQ-010 SHALL have outputs DECODE_COUNT ($clog2(DEPTH)+1, occupancy) and DECODE_ILLEGAL (1).

Function
REQ-011 SHALL push {INST_PC, INST_DATA} on a cycle with INST_VALID && INST_READY.
REQ-012 SHALL drive INST_READY = (count < DEPTH), registered state only, with no combinational path from DECODE_READY.
REQ-013 SHALL pop the head on a cycle with DECODE_VALID && DECODE_READY; DECODE_VALID = (count != 0).
REQ-014 SHALL present an entry pushed at edge N on DECODE_* outputs after edge N (1-cycle latency), in FIFO order.
REQ-015 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-016 SHALL wrap read/write pointers modulo DEPTH.
REQ-017 SHALL drive all DECODE_* field, IMM and IMM_FMT outputs to 0 when empty.
REQ-018 SHALL select format from opcode: 0110111/0010111 -> U(4); 1101111 -> J(5); 1100111/0000011/0010011 -> I(1); 0100011 -> S(2); 1100011 -> B(3); otherwise NONE(0) with IMM = 0.
REQ-019 SHALL sign-extend I/S/B/J immediates from inst[31]; U = {inst[31:12], 12'b0}; B and J bit 0 = 0.
REQ-020 SHALL, when FLUSH is high, empty the queue at that edge and ignore any push and pop in the same cycle.

Reset
REQ-021 SHALL, on RST at a clock edge, clear pointers and count; the cycle after: DECODE_VALID=0, INST_READY=1, DECODE_COUNT=0, all decode outputs 0.
REQ-022 SHALL give RST priority over FLUSH, push and pop; reset mid-fill discards all entries.

Configuration
REQ-023 SHALL use macro DECODE_ILLEGAL_CHK_EN: when defined, DECODE_ILLEGAL=1 iff the queue is non-empty and either opcode[1:0]!=2'b11 or opcode is not in {REQ-018 set, 0110011, 0001111, 1110011}; when undefined, DECODE_ILLEGAL is tied 0 (port always present).

Structure
REQ-024 SHALL place opcode constants and IMM_FMT codes (NONE..J) in shared package/header decode_pkg.
REQ-025 SHALL implement immediate/format generation as combinational sub-module decode_imm_gen (in: inst[31:0]; out: imm, fmt).

Verification
REQ-026 SHALL cover: reset, push 0xFFF00093 at PC 0x100 -> next cycle DECODE_VALID=1, PC=0x100, RD=1, IMM=0xFFFFFFFF, FMT=1.
REQ-027 SHALL cover: DECODE_READY=0, push 5 -> INST_READY=0 after the 4th, COUNT=4, 5th not accepted; then drain -> entries 1-4 in order.
REQ-028 SHALL cover: COUNT=2 with push and pop in the same cycle -> COUNT stays 2 and order is preserved.
REQ-029 SHALL cover: COUNT=3, FLUSH=1 with INST_VALID=1 -> next cycle COUNT=0, DECODE_VALID=0, incoming entry dropped.
REQ-030 SHALL cover: 0xFE000EE3 -> IMM=0xFFFFFFFC, FMT=3; 0x0080006F -> IMM=0x00000008, FMT=5; 0x12345037 -> IMM=0x12345000, FMT=4.
REQ-031 SHALL cover: push 0x00000000 -> DECODE_ILLEGAL=1 with DECODE_ILLEGAL_CHK_EN defined, 0 without.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 base opcode constants, immediate format
// codes and the opcode legality helper used by the optional illegal check.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_FMT_NONE = 3'd0,
    IMM_FMT_I    = 3'd1,
    IMM_FMT_S    = 3'd2,
    IMM_FMT_B    = 3'd3,
    IMM_FMT_U    = 3'd4,
    IMM_FMT_J    = 3'd5
  } imm_fmt_e;

  // True when the opcode is a 32-bit encoding from the supported base set.
  function automatic logic is_legal_opcode(input logic [6:0] opc);
    logic r_ok;
    r_ok = 1'b0;
    if (opc[1:0] != 2'b11) begin
      r_ok = 1'b0;
    end else begin
      case (opc)
        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM,
        OPC_STORE, OPC_BRANCH, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: r_ok = 1'b1;
        default: r_ok = 1'b0;
      endcase
    end
    return r_ok;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: picks the instruction format from the
// opcode and assembles the sign-extended 32-bit immediate for it.
module decode_imm_gen (
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm,
  output logic [2:0]  o_fmt
);
  import decode_pkg::*;

  imm_fmt_e w_fmt;

  // Format select and immediate assembly; unknown opcodes give NONE and 0.
  always_comb begin
    w_fmt = IMM_FMT_NONE;
    o_imm = 32'd0;
    case (i_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_fmt = IMM_FMT_U;
        o_imm = {i_inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        w_fmt = IMM_FMT_J;
        o_imm = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        w_fmt = IMM_FMT_I;
        o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OPC_STORE: begin
        w_fmt = IMM_FMT_S;
        o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      OPC_BRANCH: begin
        w_fmt = IMM_FMT_B;
        o_imm = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      default: begin
        w_fmt = IMM_FMT_NONE;
        o_imm = 32'd0;
      end
    endcase
  end

  assign o_fmt = w_fmt;

endmodule

// File: rtl/decode_1st_queue.sv
// First decode stage: a DEPTH-entry FIFO of fetched {PC, instruction} pairs
// whose head entry is split into fields and immediate for decode stage 2.
// Optional feature macro: DECODE_ILLEGAL_CHK_EN enables the illegal-opcode
// flag on DECODE_ILLEGAL; without it the port is tied low.
module decode_1st_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    INST_VALID,
  output logic                    INST_READY,
  input  logic [PC_WIDTH-1:0]     INST_PC,
  input  logic [31:0]             INST_DATA,
  output logic                    DECODE_VALID,
  input  logic                    DECODE_READY,
  output logic [PC_WIDTH-1:0]     DECODE_PC,
  output logic [6:0]              OPCODE,
  output logic [4:0]              RD,
  output logic [4:0]              RS1,
  output logic [4:0]              RS2,
  output logic [2:0]              FUNCT3,
  output logic [6:0]              FUNCT7,
  output logic [31:0]             DECODE_IMM,
  output logic [2:0]              DECODE_IMM_FMT,
  output logic [$clog2(DEPTH):0]  DECODE_COUNT,
  output logic                    DECODE_ILLEGAL
);
  import decode_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [31:0]         r_mem_inst [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;

  logic                w_push;
  logic                w_pop;
  logic [31:0]         w_head_inst;
  logic [PC_WIDTH-1:0] w_head_pc;

  // Ready and valid come from the registered count only, so there is no
  // combinational path from DECODE_READY back to INST_READY.
  assign INST_READY   = (r_count < CNT_FULL);
  assign DECODE_VALID = (r_count != {(AW+1){1'b0}});
  assign DECODE_COUNT = r_count;

  assign w_push = INST_VALID && INST_READY;
  assign w_pop  = DECODE_VALID && DECODE_READY;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (FLUSH) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; payload needs no reset since occupancy guards every read.
  always_ff @(posedge CLK) begin
    if (w_push && !RST && !FLUSH) begin
      r_mem_pc[r_wr_ptr]   <= INST_PC;
      r_mem_inst[r_wr_ptr] <= INST_DATA;
    end
  end

  // Head entry, forced to zero while empty so every decode output reads 0.
  always_comb begin
    w_head_inst = 32'd0;
    w_head_pc   = {PC_WIDTH{1'b0}};
    if (DECODE_VALID) begin
      w_head_inst = r_mem_inst[r_rd_ptr];
      w_head_pc   = r_mem_pc[r_rd_ptr];
    end else begin
      w_head_inst = 32'd0;
      w_head_pc   = {PC_WIDTH{1'b0}};
    end
  end

  assign DECODE_PC = w_head_pc;
  assign OPCODE    = w_head_inst[6:0];
  assign RD        = w_head_inst[11:7];
  assign FUNCT3    = w_head_inst[14:12];
  assign RS1       = w_head_inst[19:15];
  assign RS2       = w_head_inst[24:20];
  assign FUNCT7    = w_head_inst[31:25];

  decode_imm_gen u_imm_gen (
    .i_inst (w_head_inst),
    .o_imm  (DECODE_IMM),
    .o_fmt  (DECODE_IMM_FMT)
  );

`ifdef DECODE_ILLEGAL_CHK_EN
  assign DECODE_ILLEGAL = DECODE_VALID && !is_legal_opcode(w_head_inst[6:0]);
`else
  assign DECODE_ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_decode_1st_queue.sv
// Bench for decode_1st_queue: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations pinning the model.
module tb_decode_1st_queue;

  localparam int DEPTH    = 4;
  localparam int PC_WIDTH = 32;

  logic                   CLK = 1'b0;
  logic                   RST, FLUSH, INST_VALID, DECODE_READY;
  logic                   INST_READY, DECODE_VALID, DECODE_ILLEGAL;
  logic [PC_WIDTH-1:0]    INST_PC, DECODE_PC;
  logic [31:0]            INST_DATA, DECODE_IMM;
  logic [6:0]             OPCODE, FUNCT7;
  logic [4:0]             RD, RS1, RS2;
  logic [2:0]             FUNCT3, DECODE_IMM_FMT;
  logic [$clog2(DEPTH):0] DECODE_COUNT;

  decode_1st_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .INST_PC(INST_PC), .INST_DATA(INST_DATA),
    .DECODE_VALID(DECODE_VALID), .DECODE_READY(DECODE_READY),
    .DECODE_PC(DECODE_PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
    .FUNCT3(FUNCT3), .FUNCT7(FUNCT7),
    .DECODE_IMM(DECODE_IMM), .DECODE_IMM_FMT(DECODE_IMM_FMT),
    .DECODE_COUNT(DECODE_COUNT), .DECODE_ILLEGAL(DECODE_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];

  bit chk_on  = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc_n, act, exp);
    end
  endtask

  // Immediate rules written as integer arithmetic on the instruction word.
  function automatic void ref_imm(input logic [31:0] inst, output logic [31:0] imm,
                                  output logic [2:0] fmt);
    int unsigned w;
    int unsigned op;
    int v;
    w = inst;
    op = w & 32'h7F;
    imm = 32'd0;
    fmt = 3'd0;
    v = 0;
    case (op)
      32'h37, 32'h17: begin fmt = 3'd4; imm = inst & 32'hFFFFF000; end
      32'h6F: begin
        fmt = 3'd5;
        v = int'(((w >> 31) << 20) | (((w >> 12) & 255) << 12) |
                 (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1));
        if (v >= (1 << 20)) v = v - (1 << 21);
        imm = 32'(v);
      end
      32'h67, 32'h03, 32'h13: begin
        fmt = 3'd1;
        v = int'(w >> 20);
        if (v >= 2048) v = v - 4096;
        imm = 32'(v);
      end
      32'h23: begin
        fmt = 3'd2;
        v = int'(((w >> 25) << 5) | ((w >> 7) & 31));
        if (v >= 2048) v = v - 4096;
        imm = 32'(v);
      end
      32'h63: begin
        fmt = 3'd3;
        v = int'(((w >> 31) << 12) | (((w >> 7) & 1) << 11) |
                 (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1));
        if (v >= 4096) v = v - 8192;
        imm = 32'(v);
      end
      default: begin fmt = 3'd0; imm = 32'd0; end
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [31:0] inst);
    int unsigned op;
    op = inst & 32'h7F;
    case (op)
      32'h37, 32'h17, 32'h6F, 32'h67, 32'h03, 32'h13,
      32'h23, 32'h63, 32'h33, 32'h0F, 32'h73: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Per-cycle comparison of every DUT output against the reference queue.
  always @(negedge CLK) begin
    logic [31:0] e_inst, e_pc, e_imm;
    logic [2:0]  e_fmt;
    bit          e_ill;
    if (chk_on) begin
      cyc_n++;
      e_inst = 32'd0;
      e_pc   = 32'd0;
      if (q.size() != 0) begin
        e_inst = q[0].inst;
        e_pc   = q[0].pc;
      end
      ref_imm(e_inst, e_imm, e_fmt);
`ifdef DECODE_ILLEGAL_CHK_EN
      e_ill = (q.size() != 0) && ref_illegal(e_inst);
`else
      e_ill = 1'b0;
`endif
      check("decode_valid", 32'(DECODE_VALID), 32'(q.size() != 0));
      check("inst_ready",   32'(INST_READY),   32'(q.size() < DEPTH));
      check("count",        32'(DECODE_COUNT), 32'(q.size()));
      check("pc",           DECODE_PC,         e_pc);
      check("opcode",       32'(OPCODE),       e_inst & 32'h7F);
      check("rd",           32'(RD),           (e_inst >> 7) & 32'h1F);
      check("funct3",       32'(FUNCT3),       (e_inst >> 12) & 32'h7);
      check("rs1",          32'(RS1),          (e_inst >> 15) & 32'h1F);
      check("rs2",          32'(RS2),          (e_inst >> 20) & 32'h1F);
      check("funct7",       32'(FUNCT7),       e_inst >> 25);
      check("imm",          DECODE_IMM,        e_imm);
      check("imm_fmt",      32'(DECODE_IMM_FMT), 32'(e_fmt));
      check("illegal",      32'(DECODE_ILLEGAL), 32'(e_ill));
    end
  end

  // One clock: model applies the cycle's inputs at the edge, returns at negedge.
  task automatic cyc();
    bit do_push, do_pop;
    ent_t e;
    @(posedge CLK);
    if (RST || FLUSH) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && DECODE_READY;
      do_push = INST_VALID && (q.size() < DEPTH);
      e.pc    = INST_PC;
      e.inst  = INST_DATA;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
    INST_VALID = 1'b1;
    INST_PC    = pc;
    INST_DATA  = inst;
    cyc();
    INST_VALID = 1'b0;
  endtask

  task automatic imm_case(input string nm, input logic [31:0] inst,
                          input logic [31:0] imm, input logic [2:0] fmt);
    DECODE_READY = 1'b0;
    push1(32'h500, inst);
    check({nm, "_imm"}, DECODE_IMM, imm);
    check({nm, "_fmt"}, 32'(DECODE_IMM_FMT), 32'(fmt));
    DECODE_READY = 1'b1;
    cyc();
    DECODE_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; INST_VALID = 1'b0; DECODE_READY = 1'b0;
    INST_PC = 32'd0; INST_DATA = 32'd0;
    @(negedge CLK);
    cyc();
    cyc();
    RST = 1'b0;
    chk_on = 1'b1;
    check("rst_valid", 32'(DECODE_VALID), 32'd0);
    check("rst_ready", 32'(INST_READY),   32'd1);
    check("rst_count", 32'(DECODE_COUNT), 32'd0);
    check("rst_imm",   DECODE_IMM,        32'd0);

    // addi x1, x0, -1 at PC 0x100
    push1(32'h100, 32'hFFF00093);
    check("addi_valid", 32'(DECODE_VALID),   32'd1);
    check("addi_pc",    DECODE_PC,           32'h100);
    check("addi_rd",    32'(RD),             32'd1);
    check("addi_imm",   DECODE_IMM,          32'hFFFFFFFF);
    check("addi_fmt",   32'(DECODE_IMM_FMT), 32'd1);
    DECODE_READY = 1'b1;
    cyc();
    DECODE_READY = 1'b0;
    check("empty_valid", 32'(DECODE_VALID), 32'd0);
    check("empty_rd",    32'(RD),           32'd0);

    // Fill past capacity with the consumer stalled, then drain in order.
    for (int i = 0; i < 5; i++) begin
      push1(32'h200 + 32'(4 * i), 32'h13 | 32'((i + 1) << 7));
      if (i == 3) begin
        check("full_ready", 32'(INST_READY),   32'd0);
        check("full_count", 32'(DECODE_COUNT), 32'd4);
      end
    end
    check("fifth_dropped", 32'(DECODE_COUNT), 32'd4);
    DECODE_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", DECODE_PC, 32'h200 + 32'(4 * k));
      check("drain_rd", 32'(RD),   32'(k + 1));
      cyc();
    end
    DECODE_READY = 1'b0;
    check("drained", 32'(DECODE_VALID), 32'd0);

    // Simultaneous push and pop at occupancy 2.
    push1(32'h300, 32'h00000013);
    push1(32'h304, 32'h00100093);
    DECODE_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push1(32'h308 + 32'(4 * i), 32'h00200113);
      check("pp_count", 32'(DECODE_COUNT), 32'd2);
      check("pp_head",  DECODE_PC,         32'h304 + 32'(4 * i));
    end
    cyc();
    check("pp_tail1", DECODE_PC, 32'h310);
    cyc();
    DECODE_READY = 1'b0;
    check("pp_empty", 32'(DECODE_COUNT), 32'd0);

    // Flush with a concurrent push and pop.
    push1(32'h400, 32'h00000013);
    push1(32'h404, 32'h00000013);
    push1(32'h408, 32'h00000013);
    check("pre_flush", 32'(DECODE_COUNT), 32'd3);
    FLUSH = 1'b1; INST_VALID = 1'b1; DECODE_READY = 1'b1;
    INST_PC = 32'h40C; INST_DATA = 32'h00100093;
    cyc();
    FLUSH = 1'b0; INST_VALID = 1'b0; DECODE_READY = 1'b0;
    check("flush_count", 32'(DECODE_COUNT), 32'd0);
    check("flush_valid", 32'(DECODE_VALID), 32'd0);
    cyc();
    check("flush_dropped", 32'(DECODE_COUNT), 32'd0);

    // Immediate formats.
    imm_case("beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3);
    imm_case("jal",   32'h0080006F, 32'h00000008, 3'd5);
    imm_case("lui",   32'h12345037, 32'h12345000, 3'd4);
    imm_case("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2);
    imm_case("add",   32'h40B50533, 32'h00000000, 3'd0);
    imm_case("auipc", 32'h80000097, 32'h80000000, 3'd4);

    // All-zero word: not a legal opcode.
    push1(32'h600, 32'h00000000);
`ifdef DECODE_ILLEGAL_CHK_EN
    check("zero_illegal", 32'(DECODE_ILLEGAL), 32'd1);
`else
    check("zero_illegal", 32'(DECODE_ILLEGAL), 32'd0);
`endif
    check("zero_valid", 32'(DECODE_VALID), 32'd1);

    // Streaming through the pointer wrap with mixed formats.
    DECODE_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: push1(32'h700 + 32'(4 * i), 32'h80452083);
        1: push1(32'h700 + 32'(4 * i), 32'h00C58067);
        2: push1(32'h700 + 32'(4 * i), 32'h0000100F);
        default: push1(32'h700 + 32'(4 * i), 32'h0000007B);
      endcase
    end
    DECODE_READY = 1'b0;

    // Reset mid-fill overrides flush, push and pop.
    push1(32'h800, 32'h00000013);
    push1(32'h804, 32'h00000013);
    RST = 1'b1; FLUSH = 1'b1; INST_VALID = 1'b1; DECODE_READY = 1'b1;
    cyc();
    RST = 1'b0; FLUSH = 1'b0; INST_VALID = 1'b0; DECODE_READY = 1'b0;
    check("midrst_count", 32'(DECODE_COUNT), 32'd0);
    check("midrst_valid", 32'(DECODE_VALID), 32'd0);
    check("midrst_ready", 32'(INST_READY),   32'd1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
